// File: rtl/id_ex_forward_stage.sv
// rtl/id_ex_forward_stage.sv - ID/EX pipeline register with forwarding selects and load-use stall
// Optional macro STALL_COUNT_EN adds a saturating stall_count output.
module id_ex_forward_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int CTRL_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [DATA_W-1:0] in_dado_a,
    input  logic [DATA_W-1:0] in_dado_b,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_reg_write,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_dado_a,
    output logic [DATA_W-1:0] ex_dado_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
`ifdef STALL_COUNT_EN
    output logic [15:0]       stall_count,
`endif
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b
);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state, state_nxt;
    logic       haz;
    logic       bubble;
    logic [1:0] fwd_a, fwd_b;

    // The EX instruction reaches MEM next cycle, so its result outranks the older MEM one.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] r,
        input logic             ex_wr,
        input logic [REG_W-1:0] ex_dst,
        input logic             mem_wr,
        input logic [REG_W-1:0] mem_dst
    );
        if (r == '0)
            return 2'b00;
        else if (ex_wr && ex_dst == r)
            return 2'b01;
        else if (mem_wr && mem_dst == r)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        haz = in_valid & ex_valid & ex_ctrl[1] & (ex_rd != '0) &
              ((ex_rd == in_rs) | (ex_rd == in_rt));
        fwd_a = fwd_sel(in_rs, ex_valid & ex_ctrl[0], ex_rd, mem_reg_write, mem_rd);
        fwd_b = fwd_sel(in_rt, ex_valid & ex_ctrl[0], ex_rd, mem_reg_write, mem_rd);
        stall     = 1'b0;
        bubble    = flush;
        state_nxt = RUN;
        case (state)
            RUN: begin
                if (haz && !flush) begin
                    stall     = 1'b1;
                    bubble    = 1'b1;
                    state_nxt = STALL;
                end
            end
            STALL: begin
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        if (reset)
            stall = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            ex_valid  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_dado_a <= '0;
            ex_dado_b <= '0;
            ex_imm    <= '0;
            ex_ctrl   <= '0;
            sel_a     <= 2'b00;
            sel_b     <= 2'b00;
        end else begin
            state <= state_nxt;
            if (bubble) begin
                ex_valid  <= 1'b0;
                ex_rs     <= '0;
                ex_rt     <= '0;
                ex_rd     <= '0;
                ex_dado_a <= '0;
                ex_dado_b <= '0;
                ex_imm    <= '0;
                ex_ctrl   <= '0;
                sel_a     <= 2'b00;
                sel_b     <= 2'b00;
            end else begin
                ex_valid  <= in_valid;
                ex_rs     <= in_rs;
                ex_rt     <= in_rt;
                ex_rd     <= in_rd;
                ex_dado_a <= in_dado_a;
                ex_dado_b <= in_dado_b;
                ex_imm    <= in_imm;
                ex_ctrl   <= in_valid ? in_ctrl : '0;
                sel_a     <= fwd_a;
                sel_b     <= fwd_b;
            end
        end
    end

`ifdef STALL_COUNT_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_count_q <= '0;
        else if (stall && stall_count_q != 16'hFFFF)
            stall_count_q <= stall_count_q + 16'd1;
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// tb/tb_id_ex_forward_stage.sv - randomized and directed self-checking bench for id_ex_forward_stage
module tb_id_ex_forward_stage;

    localparam int DW = 16;
    localparam int RW = 3;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset, flush, in_valid, mem_reg_write;
    logic [RW-1:0] in_rs, in_rt, in_rd, mem_rd;
    logic [DW-1:0] in_dado_a, in_dado_b, in_imm;
    logic [CW-1:0] in_ctrl;
    logic          stall, ex_valid;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_dado_a, ex_dado_b, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [1:0]    sel_a, sel_b;
`ifdef STALL_COUNT_EN
    logic [15:0]   stall_count;
`endif

    id_ex_forward_stage dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_dado_a(in_dado_a), .in_dado_b(in_dado_b), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .stall(stall),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_dado_a(ex_dado_a), .ex_dado_b(ex_dado_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
`ifdef STALL_COUNT_EN
        .stall_count(stall_count),
`endif
        .sel_a(sel_a), .sel_b(sel_b)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Reference view of what EX should hold; an instruction is a record of its fields.
    typedef struct {
        logic          valid;
        logic [RW-1:0] rs, rt, rd;
        logic [DW-1:0] a, b, imm;
        logic [CW-1:0] ctrl;
        logic [1:0]    sa, sb;
    } ex_rec_t;

    ex_rec_t     m;
    ex_rec_t     empty_rec;
    bit          m_bubbled_for_load;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_sel(input logic [RW-1:0] r);
        if (r == 0) return 2'd0;
        if (m.valid && m.ctrl[0] && m.rd == r) return 2'd1;
        if (mem_reg_write && mem_rd == r) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit model_stall();
        bit load_dep;
        load_dep = in_valid && m.valid && m.ctrl[1] && m.rd != 0 && (m.rd == in_rs || m.rd == in_rt);
        return !reset && !flush && !m_bubbled_for_load && load_dep;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".ex_valid"}, ex_valid, m.valid);
        chk({tag, ".ex_rs"}, ex_rs, m.rs);
        chk({tag, ".ex_rt"}, ex_rt, m.rt);
        chk({tag, ".ex_rd"}, ex_rd, m.rd);
        chk({tag, ".ex_dado_a"}, ex_dado_a, m.a);
        chk({tag, ".ex_dado_b"}, ex_dado_b, m.b);
        chk({tag, ".ex_imm"}, ex_imm, m.imm);
        chk({tag, ".ex_ctrl"}, ex_ctrl, m.ctrl);
        chk({tag, ".sel_a"}, sel_a, m.sa);
        chk({tag, ".sel_b"}, sel_b, m.sb);
`ifdef STALL_COUNT_EN
        chk({tag, ".stall_count"}, stall_count, m_cnt);
`endif
    endtask

    task automatic drive(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic [RW-1:0] rd, input logic [CW-1:0] ctrl,
                         input logic [RW-1:0] mrd, input logic mrw, input logic fl);
        in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd; in_ctrl = ctrl;
        mem_rd = mrd; mem_reg_write = mrw; flush = fl;
        in_dado_a = DW'($urandom); in_dado_b = DW'($urandom); in_imm = DW'($urandom);
    endtask

    // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
    task automatic clock_cycle(input string tag);
        bit      s;
        ex_rec_t nxt;
        #1;
        s = model_stall();
        chk({tag, ".stall"}, stall, s);
        if (s || flush) begin
            nxt = empty_rec;
        end else begin
            nxt.valid = in_valid;
            nxt.rs = in_rs; nxt.rt = in_rt; nxt.rd = in_rd;
            nxt.a = in_dado_a; nxt.b = in_dado_b; nxt.imm = in_imm;
            nxt.ctrl = in_valid ? in_ctrl : '0;
            nxt.sa = model_sel(in_rs);
            nxt.sb = model_sel(in_rt);
        end
        @(posedge clock);
        #1;
        m = nxt;
        m_bubbled_for_load = s;
        if (s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        check_outputs(tag);
    endtask

    task automatic apply_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        m = empty_rec;
        m_bubbled_for_load = 1'b0;
        m_cnt = '0;
        check_outputs({tag, ".async"});
        chk({tag, ".stall_in_reset"}, stall, 0);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic load_use(input string tag);
        drive(1, 1, 2, 4, 8'h03, 0, 0, 0);
        clock_cycle({tag, ".load"});
        drive(1, 4, 6, 1, 8'h01, 0, 0, 0);
        clock_cycle({tag, ".hazard"});
        chk({tag, ".bubble"}, ex_valid, 0);
        drive(1, 4, 6, 1, 8'h01, 4, 1, 0);
        clock_cycle({tag, ".release"});
    endtask

    initial begin
        empty_rec = '{valid: 0, rs: 0, rt: 0, rd: 0, a: 0, b: 0, imm: 0, ctrl: 0, sa: 0, sb: 0};
        m = empty_rec;
        m_bubbled_for_load = 0;
        m_cnt = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        check_outputs("reset");
        chk("reset.stall", stall, 0);
        reset = 1'b0;

        drive(1, 0, 0, 3, 8'h01, 0, 0, 0);
        clock_cycle("b2b.n");
        drive(1, 3, 5, 1, 8'h01, 5, 1, 0);
        #1 chk("b2b.stall_lit", stall, 0);
        clock_cycle("b2b.n1");
        chk("b2b.sel_a_lit", sel_a, 2'b01);
        chk("b2b.sel_b_lit", sel_b, 2'b10);

        drive(1, 0, 0, 2, 8'h01, 0, 0, 0);
        clock_cycle("prio.a");
        drive(1, 2, 1, 0, 8'h01, 2, 1, 0);
        clock_cycle("prio.b");
        chk("prio.sel_a_lit", sel_a, 2'b01);
        drive(1, 7, 0, 1, 8'h01, 0, 1, 0);
        clock_cycle("zero.c");
        chk("zero.sel_b_lit", sel_b, 2'b00);

        drive(1, 1, 2, 4, 8'h03, 0, 0, 0);
        clock_cycle("lu.load");
        drive(1, 4, 6, 1, 8'h01, 0, 0, 0);
        #1 chk("lu.stall_lit", stall, 1);
        clock_cycle("lu.hazard");
        chk("lu.bubble_lit", ex_valid, 0);
        drive(1, 4, 6, 1, 8'h01, 4, 1, 0);
        #1 chk("lu.stall_once_lit", stall, 0);
        clock_cycle("lu.release");
        chk("lu.sel_a_lit", sel_a, 2'b10);
        chk("lu.valid_lit", ex_valid, 1);

        drive(1, 1, 2, 4, 8'h03, 0, 0, 0);
        clock_cycle("fh.load");
        drive(1, 4, 6, 1, 8'h01, 0, 0, 1);
        #1 chk("fh.stall_lit", stall, 0);
        clock_cycle("fh.flush");
        chk("fh.bubble_lit", ex_valid, 0);
        drive(1, 4, 6, 1, 8'h01, 0, 0, 0);
        clock_cycle("fh.next");
        chk("fh.run_lit", ex_valid, 1);

        drive(1, 1, 2, 4, 8'h03, 0, 0, 0);
        clock_cycle("fs.load");
        drive(1, 4, 6, 1, 8'h01, 0, 0, 0);
        clock_cycle("fs.hazard");
        drive(1, 4, 6, 1, 8'h01, 4, 1, 1);
        clock_cycle("fs.flush");
        chk("fs.no_capture_lit", ex_valid, 0);
        chk("fs.ctrl_lit", ex_ctrl, 0);

        drive(1, 1, 2, 4, 8'h03, 0, 0, 0);
        clock_cycle("rm.load");
        drive(1, 4, 6, 1, 8'h01, 0, 0, 0);
        clock_cycle("rm.hazard");
        apply_reset("rm.in_stall");
        drive(1, 5, 6, 7, 8'hA5, 0, 0, 0);
        clock_cycle("rm.valid");
        apply_reset("rm.valid_held");
        chk("rm.ex_valid_lit", ex_valid, 0);
        drive(1, 4, 6, 1, 8'h01, 0, 0, 0);
        clock_cycle("rm.after");
        chk("rm.after_valid_lit", ex_valid, 1);

`ifdef STALL_COUNT_EN
        apply_reset("cnt.clear");
        load_use("cnt1");
        load_use("cnt2");
        load_use("cnt3");
        chk("cnt.three_lit", stall_count, 16'd3);
`endif

        begin
            logic [RW-1:0] held_rs, held_rt, held_rd, load_rd;
            logic [CW-1:0] held_ctrl;
            for (int i = 0; i < 3000; i++) begin
                if (m_bubbled_for_load) begin
                    drive(1, held_rs, held_rt, held_rd, held_ctrl, load_rd, 1, ($urandom_range(0, 9) == 0));
                end else begin
                    drive(($urandom_range(0, 4) != 0), RW'($urandom), RW'($urandom), RW'($urandom),
                          CW'($urandom), RW'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
                end
                held_rs = in_rs; held_rt = in_rt; held_rd = in_rd; held_ctrl = in_ctrl;
                load_rd = m.rd;
                clock_cycle("rand");
            end
        end

`ifdef STALL_COUNT_EN
        dut.stall_count_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        load_use("sat1");
        load_use("sat2");
        chk("cnt.saturate_lit", stall_count, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
